// File: rtl/cl_hello_world_pkg.sv
// rtl/cl_hello_world_pkg.sv - shared constants, types and helpers for the hello-world register file
package cl_hello_world_pkg;

    localparam int HELLO_IDX  = 0;
    localparam int CTRL_IDX   = 1;
    localparam int STATUS_IDX = 2;

    localparam logic [31:0] RD_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        VLED_SHADOW = 2'd0,
        VLED_BLINK  = 2'd1,
        VLED_COUNT  = 2'd2,
        VLED_OFF    = 2'd3
    } vled_mode_e;

    function automatic logic [31:0] byte_swap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/cl_hello_world_regs_if.sv
// rtl/cl_hello_world_regs_if.sv - write, read-request and read-response handshakes of the register file
interface cl_hello_world_regs_if;

    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;

    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_addr;

    logic        rd_resp_valid;
    logic        rd_resp_ready;
    logic [31:0] rd_resp_data;
    logic        rd_resp_err;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_strb,
        input  wr_ready,
        output rd_valid, rd_addr,
        input  rd_ready,
        input  rd_resp_valid, rd_resp_data, rd_resp_err,
        output rd_resp_ready
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_strb,
        output wr_ready,
        input  rd_valid, rd_addr,
        output rd_ready,
        output rd_resp_valid, rd_resp_data, rd_resp_err,
        input  rd_resp_ready
    );

endinterface

// File: rtl/cl_sync_bus.sv
// rtl/cl_sync_bus.sv - multi-stage flop synchroniser for a bus of quasi-static asynchronous bits
module cl_sync_bus #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cl_hello_world_regs.sv
// rtl/cl_hello_world_regs.sv - CL register file with byte-strobed writes, buffered reads and virtual-LED modes
module cl_hello_world_regs
    import cl_hello_world_pkg::*;
#(
    parameter int          NUM_REGS    = 4,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0500,
    parameter int          VLED_W      = 16,
    parameter int          SYNC_STAGES = 2,
    parameter int          BLINK_DIV_W = 24
) (
    input  logic                 clk_main_a0,
    input  logic                 rst_main,
    cl_hello_world_regs_if.slave bus,
    input  logic [VLED_W-1:0]    sh_cl_status_vdip,
    output logic [VLED_W-1:0]    vled_q,
    output logic [VLED_W-1:0]    cl_sh_status_vled
);

    localparam int               IDX_W     = $clog2(NUM_REGS);
    localparam logic [31:0]      MAP_BYTES = 32'(4 * NUM_REGS);
    localparam logic [IDX_W-1:0] HELLO_I   = IDX_W'(HELLO_IDX);
    localparam logic [IDX_W-1:0] CTRL_I    = IDX_W'(CTRL_IDX);
    localparam logic [IDX_W-1:0] STATUS_I  = IDX_W'(STATUS_IDX);

    // The STATUS slot of regs_q is never written; STATUS is assembled live on read.
    logic [31:0]        regs_q [NUM_REGS];
    logic [31:0]        regs_d [NUM_REGS];
    logic [15:0]        wr_cnt_q;
    logic               rd_resp_valid_q;
    logic [31:0]        rd_resp_data_q;
    logic               rd_resp_err_q;
    logic [31:0]        rd_data_d;
    logic               rd_err_d;
    logic [BLINK_DIV_W-1:0] presc_q;
    logic               phase_q;
    logic [VLED_W-1:0]  cnt_q;
    logic [VLED_W-1:0]  led_q;
    logic [VLED_W-1:0]  led_d;
    logic [VLED_W-1:0]  led_out_q;
    logic [VLED_W-1:0]  vdip_sync;
    logic               wr_fire, rd_fire, wr_hit, rd_hit, mode_wr, tick;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    vled_mode_e         mode;

    function automatic logic addr_hit(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= ADDR_BASE) && ((a - ADDR_BASE) < MAP_BYTES);
    endfunction

    cl_sync_bus #(
        .WIDTH  (VLED_W),
        .STAGES (SYNC_STAGES)
    ) u_vdip_sync (
        .clk_i (clk_main_a0),
        .rst_i (rst_main),
        .d_i   (sh_cl_status_vdip),
        .q_o   (vdip_sync)
    );

    assign bus.wr_ready      = !rst_main;
    assign bus.rd_ready      = !rst_main && (!rd_resp_valid_q || bus.rd_resp_ready);
    assign bus.rd_resp_valid = rd_resp_valid_q;
    assign bus.rd_resp_data  = rd_resp_data_q;
    assign bus.rd_resp_err   = rd_resp_err_q;
    assign vled_q            = led_q;
    assign cl_sh_status_vled = led_out_q;

    assign wr_fire = bus.wr_valid && bus.wr_ready;
    assign rd_fire = bus.rd_valid && bus.rd_ready;
    assign wr_hit  = addr_hit(bus.wr_addr);
    assign rd_hit  = addr_hit(bus.rd_addr);
    assign wr_idx  = IDX_W'((bus.wr_addr - ADDR_BASE) >> 2);
    assign rd_idx  = IDX_W'((bus.rd_addr - ADDR_BASE) >> 2);
    assign mode_wr = wr_fire && wr_hit && (wr_idx == CTRL_I) && bus.wr_strb[0];
    assign tick    = &presc_q;
    assign mode    = vled_mode_e'(regs_q[CTRL_IDX][1:0]);

    always_comb begin
        regs_d = regs_q;
        if (wr_fire && wr_hit && (wr_idx != STATUS_I)) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wr_strb[b]) begin
                    regs_d[wr_idx][8*b +: 8] = bus.wr_data[8*b +: 8];
                end
            end
        end
    end

    // Decoded from the pre-write register state, so a same-cycle write is not visible.
    always_comb begin
        rd_data_d = RD_ERR_DATA;
        rd_err_d  = 1'b1;
        if (rd_hit) begin
            rd_err_d = 1'b0;
            if (rd_idx == HELLO_I) begin
                rd_data_d = byte_swap32(regs_q[HELLO_IDX]);
            end else if (rd_idx == CTRL_I) begin
                rd_data_d = {30'd0, regs_q[CTRL_IDX][1:0]};
            end else if (rd_idx == STATUS_I) begin
                rd_data_d = {wr_cnt_q, 16'(vdip_sync)};
            end else begin
                rd_data_d = regs_q[rd_idx];
            end
        end
    end

    always_comb begin
        led_d = '0;
        case (mode)
            VLED_SHADOW: led_d = regs_q[HELLO_IDX][VLED_W-1:0];
            VLED_BLINK:  led_d = phase_q ? regs_q[HELLO_IDX][VLED_W-1:0] : '0;
            VLED_COUNT:  led_d = cnt_q;
            default:     led_d = '0;
        endcase
    end

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_cnt_q        <= '0;
            rd_resp_valid_q <= 1'b0;
            rd_resp_data_q  <= '0;
            rd_resp_err_q   <= 1'b0;
            presc_q         <= '0;
            phase_q         <= 1'b0;
            cnt_q           <= '0;
            led_q           <= '0;
            led_out_q       <= '0;
        end else begin
            regs_q <= regs_d;
            if (wr_fire && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            if (rd_fire) begin
                rd_resp_valid_q <= 1'b1;
                rd_resp_data_q  <= rd_data_d;
                rd_resp_err_q   <= rd_err_d;
            end else if (bus.rd_resp_ready) begin
                rd_resp_valid_q <= 1'b0;
            end
            if (mode_wr) begin
                presc_q <= '0;
                phase_q <= 1'b1;
                cnt_q   <= '0;
            end else begin
                presc_q <= presc_q + 1'b1;
                if (tick) begin
                    phase_q <= !phase_q;
                    cnt_q   <= cnt_q + 1'b1;
                end
            end
            led_q     <= led_d;
            led_out_q <= led_q & vdip_sync;
        end
    end

endmodule

// File: tb/tb_cl_hello_world_regs.sv
// tb/tb_cl_hello_world_regs.sv - scoreboard bench for cl_hello_world_regs
module tb_cl_hello_world_regs;

    localparam int          NREGS = 6;
    localparam logic [31:0] BASE  = 32'h0000_0500;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] vdip = 16'h0000;
    logic [15:0] vled;
    logic [15:0] led_out;
    int          n_cmp = 0;
    int          n_err = 0;
    int          bp_mode = 0;
    resp_t       exp_q[$];
    logic [31:0] m_reg [NREGS];
    logic [15:0] m_cnt;
    logic [15:0] m_vdip;

    cl_hello_world_regs_if bus();

    cl_hello_world_regs #(
        .NUM_REGS    (NREGS),
        .ADDR_BASE   (BASE),
        .VLED_W      (16),
        .SYNC_STAGES (2),
        .BLINK_DIV_W (3)
    ) dut (
        .clk_main_a0       (clk),
        .rst_main          (rst),
        .bus               (bus.slave),
        .sh_cl_status_vdip (vdip),
        .vled_q            (vled),
        .cl_sh_status_vled (led_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic mapped(input logic [31:0] a);
        return (a % 4 == 0) && (a >= BASE) && (a < BASE + 4 * NREGS);
    endfunction

    function automatic resp_t model_read(input logic [31:0] a);
        resp_t r;
        int    idx;
        r.data = 32'hDEAD_BEEF;
        r.err  = 1'b1;
        if (mapped(a)) begin
            idx   = int'((a - BASE) / 4);
            r.err = 1'b0;
            case (idx)
                0:       r.data = {m_reg[0][7:0], m_reg[0][15:8], m_reg[0][23:16], m_reg[0][31:24]};
                1:       r.data = m_reg[1] & 32'h3;
                2:       r.data = {m_cnt, m_vdip};
                default: r.data = m_reg[idx];
            endcase
        end
        return r;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        if (m_cnt != 16'hFFFF) m_cnt++;
        if (mapped(a)) begin
            idx = int'((a - BASE) / 4);
            if (idx != 2) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) m_reg[idx][8*b +: 8] = d[8*b +: 8];
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
        m_cnt = '0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.wr_strb  = s;
        @(posedge clk);
        model_write(a, d, s);
        #1 bus.wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        bit ok;
        int waited;
        waited = 0;
        bus.rd_valid = 1'b1;
        bus.rd_addr  = a;
        do begin
            @(negedge clk);
            ok = bus.rd_ready;
            @(posedge clk);
            waited++;
        end while (!ok && waited < 100);
        if (ok) begin
            exp_q.push_back(model_read(a));
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL rd_accept_timeout: got no accept in %0d cycles, required accept", waited);
        end
        #1 bus.rd_valid = 1'b0;
    endtask

    task automatic do_wr_rd(input logic [31:0] a, input logic [31:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.wr_strb  = 4'hF;
        bus.rd_valid = 1'b1;
        bus.rd_addr  = a;
        @(negedge clk);
        check("same_cycle_rd_ready", 32'(bus.rd_ready), 32'd1);
        @(posedge clk);
        exp_q.push_back(model_read(a));
        model_write(a, d, 4'hF);
        #1;
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // LED pattern expected k cycles after a CTRL mode write: one step per 8-cycle prescaler period.
    function automatic logic [15:0] led_step(input int k);
        return 16'((k - 1) / 8);
    endfunction

    always @(posedge clk) begin
        #2;
        case (bp_mode)
            0:       bus.rd_resp_ready = 1'b1;
            1:       bus.rd_resp_ready = ($urandom_range(0, 3) != 0);
            default: bus.rd_resp_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst && bus.rd_resp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: got data %h, required no response", bus.rd_resp_data);
            end else begin
                check("rd_resp_data", bus.rd_resp_data, exp_q[0].data);
                check("rd_resp_err", 32'(bus.rd_resp_err), 32'(exp_q[0].err));
                if (bus.rd_resp_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.wr_strb  = '0;
        bus.rd_valid = 1'b0;
        bus.rd_addr  = '0;
        model_reset();
        m_vdip = 16'h00FF;
        vdip   = 16'h00FF;

        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_resp_valid", 32'(bus.rd_resp_valid), 32'd0);
        check("reset_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("reset_rd_ready", 32'(bus.rd_ready), 32'd0);
        check("reset_vled_q", 32'(vled), 32'd0);
        check("reset_vled_out", 32'(led_out), 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("wr_ready_idle", 32'(bus.wr_ready), 32'd1);

        do_write(BASE, 32'h0102_0304, 4'hF);
        do_read(BASE);
        do_write(BASE, 32'hFFFF_FFAA, 4'h1);
        do_read(BASE);
        do_read(BASE + 32'hA);
        do_read(32'h0000_0600);
        do_read(BASE + 32'd8);
        do_write(BASE + 32'd8, 32'h1234_5678, 4'hF);
        do_read(BASE + 32'd8);
        do_write(BASE + 32'd4, 32'hFFFF_FFFE, 4'hF);
        do_read(BASE + 32'd4);
        do_write(BASE + 32'd12, 32'hCAFE_0001, 4'hF);
        do_wr_rd(BASE + 32'd12, 32'h55AA_55AA);
        do_read(BASE + 32'd12);
        drain();

        do_write(BASE + 32'd16, 32'h1111_2222, 4'hF);
        do_write(BASE + 32'd20, 32'h3333_4444, 4'hC);
        bp_mode = 2;
        do_read(BASE + 32'd16);
        fork
            do_read(BASE + 32'd20);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("rd_ready_stall", 32'(bus.rd_ready), 32'd0);
                end
                bp_mode = 0;
            end
        join
        drain();

        do_write(BASE, 32'h0000_A5A5, 4'hF);
        do_write(BASE + 32'd4, 32'h0, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        check("shadow_vled_q", 32'(vled), 32'h0000_A5A5);
        check("shadow_vled_out", 32'(led_out), 32'h0000_00A5);
        vdip = 16'h0F0F;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check("vdip_sync_latency", 32'(led_out), (k < 3) ? 32'h0000_00A5 : 32'h0000_0505);
        end
        m_vdip = 16'h0F0F;
        do_read(BASE + 32'd8);
        drain();

        do_write(BASE + 32'd4, 32'h1, 4'hF);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            check("blink_vled_q", 32'(vled), (led_step(k) % 2 == 0) ? 32'h0000_A5A5 : 32'h0);
            if (k >= 2) check("blink_vled_out", 32'(led_out),
                              (led_step(k - 1) % 2 == 0) ? 32'h0000_0505 : 32'h0);
        end
        do_write(BASE + 32'd4, 32'h2, 4'hF);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            check("count_vled_q", 32'(vled), 32'(led_step(k)));
        end
        do_write(BASE + 32'd4, 32'h3, 4'hF);
        @(posedge clk);
        #1;
        check("off_vled_q", 32'(vled), 32'h0);

        bp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) a = BASE + 32'($urandom_range(0, 31));
            else                           a = BASE + 32'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 9) < 4) do_write(a, $urandom, 4'($urandom_range(0, 15)));
            else                          do_read(a);
        end
        drain();
        bp_mode = 0;

        do_write(BASE, 32'h0000_FFFF, 4'hF);
        do_write(BASE + 32'd4, 32'h0, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        bp_mode = 2;
        do_read(BASE + 32'd12);
        @(negedge clk);
        check("pending_before_reset", 32'(bus.rd_resp_valid), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_resp_valid", 32'(bus.rd_resp_valid), 32'd0);
        check("async_rst_resp_data", bus.rd_resp_data, 32'h0);
        check("async_rst_rd_ready", 32'(bus.rd_ready), 32'd0);
        check("async_rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("async_rst_vled_q", 32'(vled), 32'd0);
        check("async_rst_vled_out", 32'(led_out), 32'd0);
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bp_mode = 0;
        repeat (3) begin
            @(negedge clk);
            check("resp_lost_after_reset", 32'(bus.rd_resp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        do_read(BASE);
        do_read(BASE + 32'd8);
        do_read(BASE + 32'd12);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
